// File: rtl/id_ex_hazard_register.sv
// ID/EX pipeline register for the DLX core.
// Captures the decoded instruction into the EX stage, detects load-use
// hazards against the instruction already in EX, and inserts a single
// bubble while stalling PC and IF/ID. Branch flushes squash the decode
// instruction, and a downstream hold freezes the whole EX register.
// Saturating counters record stall and flush events.
module id_ex_hazard_register #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int ALU_OP_WIDTH   = 6,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid,
  input  logic [DATA_WIDTH-1:0]     id_data_a,
  input  logic [DATA_WIDTH-1:0]     id_data_b,
  input  logic [DATA_WIDTH-1:0]     id_imm,
  input  logic [REG_ADDR_WIDTH-1:0] id_addr_a,
  input  logic [REG_ADDR_WIDTH-1:0] id_addr_b,
  input  logic                      id_use_a,
  input  logic                      id_use_b,
  input  logic [REG_ADDR_WIDTH-1:0] id_wr_addr,
  input  logic                      id_reg_wr_ena,
  input  logic                      id_mem_rd,
  input  logic                      id_mem_wr,
  input  logic                      id_wb_mux_sel,
  input  logic [ALU_OP_WIDTH-1:0]   id_alu_op,
  input  logic                      flush,
  input  logic                      ex_hold,
  output logic                      ex_valid,
  output logic [DATA_WIDTH-1:0]     ex_data_a,
  output logic [DATA_WIDTH-1:0]     ex_data_b,
  output logic [DATA_WIDTH-1:0]     ex_imm,
  output logic [REG_ADDR_WIDTH-1:0] ex_addr_a,
  output logic [REG_ADDR_WIDTH-1:0] ex_addr_b,
  output logic [REG_ADDR_WIDTH-1:0] ex_wr_addr,
  output logic                      ex_reg_wr_ena,
  output logic                      ex_mem_rd,
  output logic                      ex_mem_wr,
  output logic                      ex_wb_mux_sel,
  output logic [ALU_OP_WIDTH-1:0]   ex_alu_op,
  output logic                      pc_wr_ena,
  output logic                      if_id_wr_ena,
  output logic [CNT_WIDTH-1:0]      stall_count,
  output logic [CNT_WIDTH-1:0]      flush_count
);

  logic                      ex_valid_q,      ex_valid_d;
  logic [DATA_WIDTH-1:0]     ex_data_a_q,     ex_data_a_d;
  logic [DATA_WIDTH-1:0]     ex_data_b_q,     ex_data_b_d;
  logic [DATA_WIDTH-1:0]     ex_imm_q,        ex_imm_d;
  logic [REG_ADDR_WIDTH-1:0] ex_addr_a_q,     ex_addr_a_d;
  logic [REG_ADDR_WIDTH-1:0] ex_addr_b_q,     ex_addr_b_d;
  logic [REG_ADDR_WIDTH-1:0] ex_wr_addr_q,    ex_wr_addr_d;
  logic                      ex_reg_wr_ena_q, ex_reg_wr_ena_d;
  logic                      ex_mem_rd_q,     ex_mem_rd_d;
  logic                      ex_mem_wr_q,     ex_mem_wr_d;
  logic                      ex_wb_mux_sel_q, ex_wb_mux_sel_d;
  logic [ALU_OP_WIDTH-1:0]   ex_alu_op_q,     ex_alu_op_d;
  logic [CNT_WIDTH-1:0]      stall_count_q,   stall_count_d;
  logic [CNT_WIDTH-1:0]      flush_count_q,   flush_count_d;

  logic hz;
  logic src_a_match;
  logic src_b_match;
  logic stall_event;

  // Load-use hazard: the load in EX writes a non-zero register that decode reads.
  always_comb begin
    src_a_match = id_use_a & (id_addr_a == ex_wr_addr_q);
    src_b_match = id_use_b & (id_addr_b == ex_wr_addr_q);
    hz = id_valid & ex_valid_q & ex_mem_rd_q & ex_reg_wr_ena_q &
         (ex_wr_addr_q != '0) & (src_a_match | src_b_match);
  end

  // A flush squashes decode anyway, so a hazard only stalls the front end without one.
  assign pc_wr_ena    = ~(ex_hold | (hz & ~flush));
  assign if_id_wr_ena = pc_wr_ena;

  assign stall_event = hz & ~flush & ~ex_hold;

  // Next EX contents: flush beats hold, hold beats hazard bubble, else capture decode.
  always_comb begin
    ex_valid_d      = ex_valid_q;
    ex_data_a_d     = ex_data_a_q;
    ex_data_b_d     = ex_data_b_q;
    ex_imm_d        = ex_imm_q;
    ex_addr_a_d     = ex_addr_a_q;
    ex_addr_b_d     = ex_addr_b_q;
    ex_wr_addr_d    = ex_wr_addr_q;
    ex_reg_wr_ena_d = ex_reg_wr_ena_q;
    ex_mem_rd_d     = ex_mem_rd_q;
    ex_mem_wr_d     = ex_mem_wr_q;
    ex_wb_mux_sel_d = ex_wb_mux_sel_q;
    ex_alu_op_d     = ex_alu_op_q;
    if (flush || (!ex_hold && hz)) begin
      ex_valid_d      = 1'b0;
      ex_data_a_d     = '0;
      ex_data_b_d     = '0;
      ex_imm_d        = '0;
      ex_addr_a_d     = '0;
      ex_addr_b_d     = '0;
      ex_wr_addr_d    = '0;
      ex_reg_wr_ena_d = 1'b0;
      ex_mem_rd_d     = 1'b0;
      ex_mem_wr_d     = 1'b0;
      ex_wb_mux_sel_d = 1'b0;
      ex_alu_op_d     = '0;
    end else if (!ex_hold) begin
      ex_valid_d      = id_valid;
      ex_data_a_d     = id_data_a;
      ex_data_b_d     = id_data_b;
      ex_imm_d        = id_imm;
      ex_addr_a_d     = id_addr_a;
      ex_addr_b_d     = id_addr_b;
      ex_wr_addr_d    = id_wr_addr;
      ex_reg_wr_ena_d = id_reg_wr_ena & id_valid;
      ex_mem_rd_d     = id_mem_rd & id_valid;
      ex_mem_wr_d     = id_mem_wr & id_valid;
      ex_wb_mux_sel_d = id_wb_mux_sel;
      ex_alu_op_d     = id_alu_op;
    end
  end

  // Event counters stick at all-ones instead of wrapping.
  always_comb begin
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    if (stall_event && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + 1'b1;
    end
    if (flush && (flush_count_q != '1)) begin
      flush_count_d = flush_count_q + 1'b1;
    end
  end

  // All state updates on the rising edge; reset clears everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q      <= 1'b0;
      ex_data_a_q     <= '0;
      ex_data_b_q     <= '0;
      ex_imm_q        <= '0;
      ex_addr_a_q     <= '0;
      ex_addr_b_q     <= '0;
      ex_wr_addr_q    <= '0;
      ex_reg_wr_ena_q <= 1'b0;
      ex_mem_rd_q     <= 1'b0;
      ex_mem_wr_q     <= 1'b0;
      ex_wb_mux_sel_q <= 1'b0;
      ex_alu_op_q     <= '0;
      stall_count_q   <= '0;
      flush_count_q   <= '0;
    end else begin
      ex_valid_q      <= ex_valid_d;
      ex_data_a_q     <= ex_data_a_d;
      ex_data_b_q     <= ex_data_b_d;
      ex_imm_q        <= ex_imm_d;
      ex_addr_a_q     <= ex_addr_a_d;
      ex_addr_b_q     <= ex_addr_b_d;
      ex_wr_addr_q    <= ex_wr_addr_d;
      ex_reg_wr_ena_q <= ex_reg_wr_ena_d;
      ex_mem_rd_q     <= ex_mem_rd_d;
      ex_mem_wr_q     <= ex_mem_wr_d;
      ex_wb_mux_sel_q <= ex_wb_mux_sel_d;
      ex_alu_op_q     <= ex_alu_op_d;
      stall_count_q   <= stall_count_d;
      flush_count_q   <= flush_count_d;
    end
  end

  assign ex_valid      = ex_valid_q;
  assign ex_data_a     = ex_data_a_q;
  assign ex_data_b     = ex_data_b_q;
  assign ex_imm        = ex_imm_q;
  assign ex_addr_a     = ex_addr_a_q;
  assign ex_addr_b     = ex_addr_b_q;
  assign ex_wr_addr    = ex_wr_addr_q;
  assign ex_reg_wr_ena = ex_reg_wr_ena_q;
  assign ex_mem_rd     = ex_mem_rd_q;
  assign ex_mem_wr     = ex_mem_wr_q;
  assign ex_wb_mux_sel = ex_wb_mux_sel_q;
  assign ex_alu_op     = ex_alu_op_q;
  assign stall_count   = stall_count_q;
  assign flush_count   = flush_count_q;

endmodule

// File: tb/tb_id_ex_hazard_register.sv
// Directed bench for the ID/EX hazard register, built with 4-bit counters
// so that counter saturation is reachable in a short run.
module tb_id_ex_hazard_register;

  localparam int CW      = 4;
  localparam int CNT_MAX = 15;

  typedef struct packed {
    logic        valid;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [4:0]  aa;
    logic [4:0]  ab;
    logic        ua;
    logic        ub;
    logic [4:0]  wa;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        wb;
    logic [5:0]  op;
  } instr_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [4:0]  aa;
    logic [4:0]  ab;
    logic [4:0]  wa;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        wb;
    logic [5:0]  op;
  } ex_t;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [31:0] id_data_a, id_data_b, id_imm;
  logic [4:0]  id_addr_a, id_addr_b, id_wr_addr;
  logic        id_use_a, id_use_b;
  logic        id_reg_wr_ena, id_mem_rd, id_mem_wr, id_wb_mux_sel;
  logic [5:0]  id_alu_op;
  logic        flush, ex_hold;
  logic        ex_valid;
  logic [31:0] ex_data_a, ex_data_b, ex_imm;
  logic [4:0]  ex_addr_a, ex_addr_b, ex_wr_addr;
  logic        ex_reg_wr_ena, ex_mem_rd, ex_mem_wr, ex_wb_mux_sel;
  logic [5:0]  ex_alu_op;
  logic        pc_wr_ena, if_id_wr_ena;
  logic [CW-1:0] stall_count, flush_count;

  int total = 0;
  int bad   = 0;
  int expStall = 0;
  int expFlush = 0;
  ex_t expQ[$];

  id_ex_hazard_register #(
    .DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .ALU_OP_WIDTH(6), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_data_a(id_data_a), .id_data_b(id_data_b), .id_imm(id_imm),
    .id_addr_a(id_addr_a), .id_addr_b(id_addr_b),
    .id_use_a(id_use_a), .id_use_b(id_use_b), .id_wr_addr(id_wr_addr),
    .id_reg_wr_ena(id_reg_wr_ena), .id_mem_rd(id_mem_rd), .id_mem_wr(id_mem_wr),
    .id_wb_mux_sel(id_wb_mux_sel), .id_alu_op(id_alu_op),
    .flush(flush), .ex_hold(ex_hold),
    .ex_valid(ex_valid), .ex_data_a(ex_data_a), .ex_data_b(ex_data_b), .ex_imm(ex_imm),
    .ex_addr_a(ex_addr_a), .ex_addr_b(ex_addr_b), .ex_wr_addr(ex_wr_addr),
    .ex_reg_wr_ena(ex_reg_wr_ena), .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr),
    .ex_wb_mux_sel(ex_wb_mux_sel), .ex_alu_op(ex_alu_op),
    .pc_wr_ena(pc_wr_ena), .if_id_wr_ena(if_id_wr_ena),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run can never hang.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic ex_t captured(instr_t i);
    ex_t e;
    e.valid = i.valid;
    e.a     = i.a;
    e.b     = i.b;
    e.imm   = i.imm;
    e.aa    = i.aa;
    e.ab    = i.ab;
    e.wa    = i.wa;
    e.rw    = i.rw & i.valid;
    e.mr    = i.mr & i.valid;
    e.mw    = i.mw & i.valid;
    e.wb    = i.wb;
    e.op    = i.op;
    return e;
  endfunction

  function automatic instr_t mkInstr(logic v, logic [31:0] a, logic [31:0] b, logic [31:0] imm,
                                     logic [4:0] aa, logic [4:0] ab, logic ua, logic ub,
                                     logic [4:0] wa, logic rw, logic mr, logic mw,
                                     logic wb, logic [5:0] op);
    instr_t i;
    i.valid = v; i.a = a; i.b = b; i.imm = imm; i.aa = aa; i.ab = ab;
    i.ua = ua; i.ub = ub; i.wa = wa; i.rw = rw; i.mr = mr; i.mw = mw;
    i.wb = wb; i.op = op;
    return i;
  endfunction

  function automatic int bump(int v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input instr_t i, input logic fl, input logic hold);
    id_valid      = i.valid;
    id_data_a     = i.a;
    id_data_b     = i.b;
    id_imm        = i.imm;
    id_addr_a     = i.aa;
    id_addr_b     = i.ab;
    id_use_a      = i.ua;
    id_use_b      = i.ub;
    id_wr_addr    = i.wa;
    id_reg_wr_ena = i.rw;
    id_mem_rd     = i.mr;
    id_mem_wr     = i.mw;
    id_wb_mux_sel = i.wb;
    id_alu_op     = i.op;
    flush         = fl;
    ex_hold       = hold;
  endtask

  task automatic checkOutput();
    ex_t e;
    if (expQ.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = expQ.pop_front();
    chk("ex_valid",      {31'd0, ex_valid},      {31'd0, e.valid});
    chk("ex_data_a",     ex_data_a,              e.a);
    chk("ex_data_b",     ex_data_b,              e.b);
    chk("ex_imm",        ex_imm,                 e.imm);
    chk("ex_addr_a",     {27'd0, ex_addr_a},     {27'd0, e.aa});
    chk("ex_addr_b",     {27'd0, ex_addr_b},     {27'd0, e.ab});
    chk("ex_wr_addr",    {27'd0, ex_wr_addr},    {27'd0, e.wa});
    chk("ex_reg_wr_ena", {31'd0, ex_reg_wr_ena}, {31'd0, e.rw});
    chk("ex_mem_rd",     {31'd0, ex_mem_rd},     {31'd0, e.mr});
    chk("ex_mem_wr",     {31'd0, ex_mem_wr},     {31'd0, e.mw});
    chk("ex_wb_mux_sel", {31'd0, ex_wb_mux_sel}, {31'd0, e.wb});
    chk("ex_alu_op",     {26'd0, ex_alu_op},     {26'd0, e.op});
    chk("stall_count",   {28'd0, stall_count},   expStall);
    chk("flush_count",   {28'd0, flush_count},   expFlush);
  endtask

  // One clock: push the expected EX state, check stall outputs before the
  // edge, then compare the registered state just after it.
  task automatic step(input ex_t e, input logic expPc);
    expQ.push_back(e);
    #3;
    chk("pc_wr_ena",    {31'd0, pc_wr_ena},    {31'd0, expPc});
    chk("if_id_wr_ena", {31'd0, if_id_wr_ena}, {31'd0, expPc});
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    ex_t    bubble;
    instr_t add1, lw4, useR4, lw0, useR0, noUse, inval;

    bubble = '0;
    add1  = mkInstr(1, 32'd5,   32'd7, 32'd0, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0, 0, 6'h20);
    lw4   = mkInstr(1, 32'd100, 32'd0, 32'd8, 5'd1, 5'd0, 1, 0, 5'd4, 1, 1, 0, 1, 6'h01);
    useR4 = mkInstr(1, 32'd11,  32'd22, 32'd0, 5'd4, 5'd6, 1, 1, 5'd5, 1, 0, 0, 0, 6'h20);
    lw0   = mkInstr(1, 32'd200, 32'd0, 32'd4, 5'd1, 5'd0, 1, 0, 5'd0, 1, 1, 0, 1, 6'h01);
    useR0 = mkInstr(1, 32'd33,  32'd44, 32'd0, 5'd0, 5'd0, 1, 1, 5'd7, 1, 0, 0, 0, 6'h21);
    noUse = mkInstr(1, 32'd55,  32'd66, 32'hFFFF_FFF0, 5'd4, 5'd4, 0, 0, 5'd8, 1, 0, 0, 0, 6'h0F);
    inval = mkInstr(0, 32'hDEAD_BEEF, 32'h0BAD_F00D, 32'd9, 5'd4, 5'd4, 1, 1, 5'd4, 1, 1, 1, 1, 6'h3F);

    // Reset with a live instruction on the inputs.
    rst = 1'b1;
    applyStimulus(mkInstr(1, 32'h1234, 32'd0, 32'd0, 5'd0, 5'd0, 0, 0, 5'd0, 1, 1, 1, 1, 6'h3F), 0, 0);
    expQ.push_back(bubble);
    @(posedge clk);
    #1;
    checkOutput();
    step(bubble, 1'b1);
    rst = 1'b0;

    // Normal flow.
    applyStimulus(add1, 0, 0);  step(captured(add1), 1'b1);
    // Load-use: one bubble, then the consumer enters EX.
    applyStimulus(lw4, 0, 0);   step(captured(lw4), 1'b1);
    applyStimulus(useR4, 0, 0); expStall = bump(expStall); step(bubble, 1'b0);
    applyStimulus(useR4, 0, 0); step(captured(useR4), 1'b1);
    // Load to r0 never stalls.
    applyStimulus(lw0, 0, 0);   step(captured(lw0), 1'b1);
    applyStimulus(useR0, 0, 0); step(captured(useR0), 1'b1);
    // Matching addresses that are not actually read never stall.
    applyStimulus(lw4, 0, 0);   step(captured(lw4), 1'b1);
    applyStimulus(noUse, 0, 0); step(captured(noUse), 1'b1);
    // Flush with hazard and hold all active: bubble, stall outputs follow hold.
    applyStimulus(lw4, 0, 0);   step(captured(lw4), 1'b1);
    applyStimulus(useR4, 1, 1); expFlush = bump(expFlush); step(bubble, 1'b0);
    // Hold with a pending hazard for three cycles: EX frozen, no stall counted.
    applyStimulus(lw4, 0, 0);   step(captured(lw4), 1'b1);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(useR4, 0, 1); step(captured(lw4), 1'b0);
    end
    // Release: hazard re-evaluated, one bubble.
    applyStimulus(useR4, 0, 0); expStall = bump(expStall); step(bubble, 1'b0);
    applyStimulus(useR4, 0, 0); step(captured(useR4), 1'b1);
    // Invalid decode slot: controls forced low.
    applyStimulus(inval, 0, 0); step(captured(inval), 1'b1);

    // Drive the stall counter well past its 4-bit ceiling.
    for (int k = 0; k < 20; k++) begin
      applyStimulus(lw4, 0, 0);   step(captured(lw4), 1'b1);
      applyStimulus(useR4, 0, 0); expStall = bump(expStall); step(bubble, 1'b0);
      applyStimulus(useR4, 0, 0); step(captured(useR4), 1'b1);
    end
    chk("stall_saturated", {28'd0, stall_count}, 32'd15);

    // Reset while a hazard is pending clears everything.
    applyStimulus(lw4, 0, 0);   step(captured(lw4), 1'b1);
    applyStimulus(useR4, 0, 0);
    rst = 1'b1;
    expStall = 0;
    expFlush = 0;
    step(bubble, 1'b0);
    rst = 1'b0;
    #3;
    chk("pc_after_reset", {31'd0, pc_wr_ena}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_hazard_register.md
Name: id_ex_hazard_register

Overview:
- ID/EX pipeline register of the DLX core; sits between the decode stage and the execute-stage forwarding/ALU logic.
- Captures decoded operands, register addresses and control bits into the EX stage.
- Detects load-use hazards, inserts one bubble and stalls PC and IF/ID while it does.
- Handles branch flush and downstream hold; keeps saturating stall/flush event counters.

Parameters:
- DATA_WIDTH, 32, operand/immediate width
- REG_ADDR_WIDTH, 5, register-file address width
- ALU_OP_WIDTH, 6, ALU opcode width
- CNT_WIDTH, 16, event counter width

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- id_valid  in  1  decode holds a real instruction
- id_data_a / id_data_b  in  DATA_WIDTH  register-file read data
- id_imm  in  DATA_WIDTH  sign-extended immediate
- id_addr_a / id_addr_b  in  REG_ADDR_WIDTH  source register addresses
- id_use_a / id_use_b  in  1  instruction actually reads that source
- id_wr_addr  in  REG_ADDR_WIDTH  destination register
- id_reg_wr_ena, id_mem_rd, id_mem_wr, id_wb_mux_sel  in  1  control bits
- id_alu_op  in  ALU_OP_WIDTH  ALU operation
- flush  in  1  branch taken, squash the decode instruction
- ex_hold  in  1  downstream stall, freeze EX register
- ex_valid  out  1  EX holds a real instruction
- ex_data_a / ex_data_b / ex_imm  out  DATA_WIDTH  registered operands
- ex_addr_a / ex_addr_b / ex_wr_addr  out  REG_ADDR_WIDTH  registered addresses (feed forwarding)
- ex_reg_wr_ena, ex_mem_rd, ex_mem_wr, ex_wb_mux_sel  out  1  registered controls
- ex_alu_op  out  ALU_OP_WIDTH  registered ALU op
- pc_wr_ena  out  1  0 = hold PC
- if_id_wr_ena  out  1  0 = hold IF/ID register
- stall_count / flush_count  out  CNT_WIDTH  saturating event counters

Behaviour:
- Reset (rst=1 at an edge): every registered output is 0, including ex_valid, all controls, data and addresses, and both counters. Reset overrides all other inputs, including mid-stall.
- Hazard (combinational): hz = id_valid & ex_valid & ex_mem_rd & ex_reg_wr_ena & (ex_wr_addr != 0) & ((id_use_a & id_addr_a == ex_wr_addr) | (id_use_b & id_addr_b == ex_wr_addr)).
- Writes to r0 never create a hazard.
- pc_wr_ena = if_id_wr_ena = ~(ex_hold | (hz & ~flush)). Combinational; no reset dependency beyond the registered EX state.
- Register update priority at each edge:
  - rst: as above.
  - flush=1: load a bubble (ex_valid, reg_wr_ena, mem_rd, mem_wr = 0; other fields don't-care, drive 0). flush overrides ex_hold and hz.
  - ex_hold=1: all EX registers keep their value.
  - hz=1: load a bubble. Decode is held by the stall outputs, so the same instruction re-presents next cycle. hz is then 0 because the bubble has ex_mem_rd=0.
  - otherwise: capture all id_* fields. ex_valid = id_valid. When id_valid=0, force reg_wr_ena/mem_rd/mem_wr to 0.
- Latency: 1 cycle from ID to EX. A load-use pair costs exactly one bubble cycle.
- Counters:
  - stall_count increments once per edge where hz & ~flush & ~ex_hold.
  - flush_count increments once per edge where flush=1.
  - Both saturate at all-ones and never wrap.
- ex_hold and hz together: hold wins, no bubble, stall_count not incremented. Hazard is re-evaluated after the hold releases.

Test Plan:
- Reset: drive id_valid=1, id_data_a=0x1234 with rst=1 for 2 cycles → all outputs 0, counters 0, pc_wr_ena=1.
- Normal flow: ADD with id_data_a=5, id_data_b=7, id_wr_addr=3, id_alu_op=0x20 → next cycle ex_data_a=5, ex_data_b=7, ex_wr_addr=3, ex_valid=1, no stall.
- Load-use: LW r4 then ADD using r4 as source a → exactly one cycle with pc_wr_ena=if_id_wr_ena=0 and EX bubble (ex_valid=0). ADD enters EX the following cycle; stall_count=1.
- r0 / unused source: LW r0 then ADD r0, or LW r4 then instruction with id_use_a=id_use_b=0 → no stall, stall_count unchanged.
- Flush vs hazard vs hold: flush=1 with hz=1 and ex_hold=1 → bubble loaded, stall outputs follow ex_hold only, flush_count+1, stall_count unchanged. ex_hold=1 for 3 cycles → EX registers unchanged, pc_wr_ena=0.
- Saturation: CNT_WIDTH=4, force 20 load-use stalls → stall_count sticks at 15.
